// File: rtl/snake_collision_scan.sv
// Per-tick collision scan: compares the snake head against body segments 1..len-1 read from
// a synchronous segment RAM, then against the food position, and reports the first body hit.
module snake_collision_scan #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [19:0]       head,
    input  logic [19:0]       food,
    input  logic [ADDR_W:0]   length,
    output logic              seg_rd,
    output logic [ADDR_W-1:0] seg_addr,
    input  logic [19:0]       seg_data,
    output logic              busy,
    output logic              done,
    output logic              hit_body,
    output logic [ADDR_W-1:0] hit_index,
    output logic              hit_food
);

    typedef enum logic [1:0] {IDLE, SCAN, FOOD, REPORT} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_reg, state_next;
    logic [19:0]       head_reg, food_reg;
    logic [ADDR_W-1:0] last_idx_reg;
    logic [ADDR_W-1:0] cmp_idx_reg;
    logic              cmp_valid_reg;
    logic              seg_rd_reg, seg_rd_next;
    logic [ADDR_W-1:0] seg_addr_reg, seg_addr_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              hit_body_reg, hit_food_reg;
    logic [ADDR_W-1:0] hit_index_reg;
    logic [ADDR_W-1:0] start_last_idx;

    // Instance 0 checks the returning segment word, instance 1 checks head against food.
    logic [19:0] cmp_a [2];
    logic [19:0] cmp_b [2];
    logic [1:0]  cmp_f;
    logic [1:0]  cmp_eq;

    assign cmp_a[0] = seg_data;
    assign cmp_b[0] = head_reg;
    assign cmp_a[1] = head_reg;
    assign cmp_b[1] = food_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cmp
            twentyBitComparitor u_cmp (
                .a (cmp_a[gi]),
                .b (cmp_b[gi]),
                .F (cmp_f[gi])
            );
            assign cmp_eq[gi] = ~cmp_f[gi];
        end
    endgenerate

    logic body_match;
    logic last_cmp;
    assign body_match = cmp_valid_reg & cmp_eq[0];
    assign last_cmp   = cmp_valid_reg & (cmp_idx_reg == last_idx_reg);

    // Highest index to read; zero means there is no body to scan.
    always_comb begin
        start_last_idx = '0;
        if (length == '0) begin
            start_last_idx = '0;
        end else if (length > MAX_LEN) begin
            start_last_idx = '1;
        end else begin
            start_last_idx = ADDR_W'(length - (ADDR_W+1)'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (start_last_idx == '0) ? FOOD : SCAN;
                end
            end
            SCAN: begin
                if (body_match || last_cmp) begin
                    state_next = FOOD;
                end
            end
            FOOD:    state_next = REPORT;
            REPORT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs are computed one cycle ahead and registered below.
    always_comb begin
        seg_rd_next   = 1'b0;
        seg_addr_next = '0;
        case (state_reg)
            IDLE: begin
                if (state_next == SCAN) begin
                    seg_rd_next   = 1'b1;
                    seg_addr_next = ADDR_W'(1);
                end
            end
            SCAN: begin
                if (state_next == SCAN && seg_rd_reg && seg_addr_reg != last_idx_reg) begin
                    seg_rd_next   = 1'b1;
                    seg_addr_next = seg_addr_reg + ADDR_W'(1);
                end
            end
            default: begin
                seg_rd_next   = 1'b0;
                seg_addr_next = '0;
            end
        endcase
        busy_next = (state_next != IDLE);
        done_next = (state_next == REPORT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_rd_reg    <= 1'b0;
            seg_addr_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            hit_body_reg  <= 1'b0;
            hit_index_reg <= '0;
            hit_food_reg  <= 1'b0;
            head_reg      <= '0;
            food_reg      <= '0;
            last_idx_reg  <= '0;
            cmp_valid_reg <= 1'b0;
            cmp_idx_reg   <= '0;
        end else begin
            seg_rd_reg    <= seg_rd_next;
            seg_addr_reg  <= seg_addr_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            cmp_valid_reg <= seg_rd_reg;
            cmp_idx_reg   <= seg_addr_reg;
            if (state_reg == IDLE && start) begin
                head_reg      <= head;
                food_reg      <= food;
                last_idx_reg  <= start_last_idx;
                hit_body_reg  <= 1'b0;
                hit_index_reg <= '0;
                hit_food_reg  <= 1'b0;
            end
            // A read still in flight after a hit lands in FOOD and is ignored there.
            if (state_reg == SCAN && body_match) begin
                hit_body_reg  <= 1'b1;
                hit_index_reg <= cmp_idx_reg;
            end
            if (state_reg == FOOD) begin
                hit_food_reg <= cmp_eq[1];
            end
        end
    end

    assign seg_rd    = seg_rd_reg;
    assign seg_addr  = seg_addr_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign hit_body  = hit_body_reg;
    assign hit_index = hit_index_reg;
    assign hit_food  = hit_food_reg;

endmodule

// Shared 20-bit equality comparator: F is low when the operands are equal.
module twentyBitComparitor (
    input  logic [19:0] a,
    input  logic [19:0] b,
    output logic        F
);
    assign F = |(a ^ b);
endmodule

// File: tb/tb_snake_collision_scan.sv
// Directed bench for snake_collision_scan with a synchronous segment RAM model.
module tb_snake_collision_scan;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [19:0]       head;
    logic [19:0]       food;
    logic [ADDR_W:0]   length;
    logic              seg_rd;
    logic [ADDR_W-1:0] seg_addr;
    logic [19:0]       seg_data = '0;
    logic              busy;
    logic              done;
    logic              hit_body;
    logic [ADDR_W-1:0] hit_index;
    logic              hit_food;

    int checks = 0;
    int failures = 0;

    logic [19:0]       ram [32];
    logic              rd_tr [64];
    logic              done_tr [64];
    logic              busy_tr [64];
    logic              hb_tr [64];
    logic              hf_tr [64];
    logic [ADDR_W-1:0] addr_tr [64];
    logic [ADDR_W-1:0] hi_tr [64];
    int s_nrd, s_contig, s_done_cyc, s_ndone, s_nbusy;

    snake_collision_scan #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .head      (head),
        .food      (food),
        .length    (length),
        .seg_rd    (seg_rd),
        .seg_addr  (seg_addr),
        .seg_data  (seg_data),
        .busy      (busy),
        .done      (done),
        .hit_body  (hit_body),
        .hit_index (hit_index),
        .hit_food  (hit_food)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (seg_rd) seg_data <= ram[seg_addr];
    end

    task fill_ram();
        for (int i = 0; i < 32; i++) ram[i] = 20'hF0000 | 20'(i);
    endtask

    task pulse_start(input logic [19:0] h, input logic [19:0] f, input logic [ADDR_W:0] len);
        @(negedge clk);
        head = h; food = f; length = len; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Records outputs for cycles 1..ncyc after the accepting edge.
    task capture(input int ncyc);
        for (int n = 1; n <= ncyc; n++) begin
            @(negedge clk);
            rd_tr[n] = seg_rd; addr_tr[n] = seg_addr; done_tr[n] = done; busy_tr[n] = busy;
            hb_tr[n] = hit_body; hi_tr[n] = hit_index; hf_tr[n] = hit_food;
        end
    endtask

    task summarize(input int ncyc);
        s_nrd = 0; s_contig = 1; s_done_cyc = 0; s_ndone = 0; s_nbusy = 0;
        for (int n = 1; n <= ncyc; n++) begin
            if (rd_tr[n] === 1'b1) begin
                s_nrd++;
                if (n != s_nrd || addr_tr[n] !== ADDR_W'(n)) s_contig = 0;
            end
            if (done_tr[n] === 1'b1) begin
                s_ndone++;
                if (s_done_cyc == 0) s_done_cyc = n;
            end
            if (busy_tr[n] === 1'b1) s_nbusy++;
        end
    endtask

    task test_reset();
        reset = 1'b1; start = 1'b1; head = 20'h12345; food = 20'h12345; length = 6'd3;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk);
        checks++; if (seg_rd !== 1'b0) begin failures++; $display("FAIL reset_seg_rd got=%b exp=0", seg_rd); end
        checks++; if (seg_addr !== '0) begin failures++; $display("FAIL reset_seg_addr got=%0d exp=0", seg_addr); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (hit_body !== 1'b0) begin failures++; $display("FAIL reset_hit_body got=%b exp=0", hit_body); end
        checks++; if (hit_index !== '0) begin failures++; $display("FAIL reset_hit_index got=%0d exp=0", hit_index); end
        checks++; if (hit_food !== 1'b0) begin failures++; $display("FAIL reset_hit_food got=%b exp=0", hit_food); end
        reset = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_release_busy got=%b exp=0", busy); end
        $display("reset: outputs checked during and after reset");
    endtask

    task test_body_last();
        fill_ram();
        ram[1] = 20'h0300C; ram[2] = 20'h0500C; ram[3] = 20'h0700C; ram[4] = 20'h0A00B;
        pulse_start(20'h0A00B, 20'h01001, 6'd5);
        capture(10); summarize(10);
        checks++; if (s_nrd !== 4) begin failures++; $display("FAIL body_last n_reads got=%0d exp=4", s_nrd); end
        checks++; if (s_contig !== 1) begin failures++; $display("FAIL body_last read_seq got=%0d exp=1", s_contig); end
        checks++; if (s_done_cyc !== 7) begin failures++; $display("FAIL body_last done_cycle got=%0d exp=7", s_done_cyc); end
        checks++; if (s_ndone !== 1) begin failures++; $display("FAIL body_last done_count got=%0d exp=1", s_ndone); end
        checks++; if (s_nbusy !== 7) begin failures++; $display("FAIL body_last busy_cycles got=%0d exp=7", s_nbusy); end
        checks++; if (hb_tr[7] !== 1'b1 || hi_tr[7] !== 5'd4 || hf_tr[7] !== 1'b0) begin failures++;
            $display("FAIL body_last result got=%b/%0d/%b exp=1/4/0", hb_tr[7], hi_tr[7], hf_tr[7]); end
        checks++; if (hb_tr[9] !== 1'b1 || hi_tr[9] !== 5'd4) begin failures++;
            $display("FAIL body_last hold got=%b/%0d exp=1/4", hb_tr[9], hi_tr[9]); end
        $display("body_last: reads=%0d done@%0d hit=%b idx=%0d food=%b", s_nrd, s_done_cyc, hb_tr[7], hi_tr[7], hf_tr[7]);
    endtask

    task test_early_hit();
        fill_ram();
        ram[2] = 20'h2B0C7; ram[5] = 20'h2B0C7;
        pulse_start(20'h2B0C7, 20'h00001, 6'd8);
        capture(8); summarize(8);
        checks++; if (s_nrd !== 3) begin failures++; $display("FAIL early_hit n_reads got=%0d exp=3", s_nrd); end
        checks++; if (s_contig !== 1) begin failures++; $display("FAIL early_hit read_seq got=%0d exp=1", s_contig); end
        checks++; if (s_done_cyc !== 5) begin failures++; $display("FAIL early_hit done_cycle got=%0d exp=5", s_done_cyc); end
        checks++; if (hb_tr[5] !== 1'b1 || hi_tr[5] !== 5'd2 || hf_tr[5] !== 1'b0) begin failures++;
            $display("FAIL early_hit result got=%b/%0d/%b exp=1/2/0", hb_tr[5], hi_tr[5], hf_tr[5]); end
        $display("early_hit: reads=%0d done@%0d hit=%b idx=%0d", s_nrd, s_done_cyc, hb_tr[5], hi_tr[5]);
    endtask

    task test_food_only();
        fill_ram();
        for (int l = 1; l >= 0; l--) begin
            pulse_start(20'h12345, 20'h12345, 6'(l));
            capture(5); summarize(5);
            checks++; if (s_nrd !== 0) begin failures++; $display("FAIL food_only len=%0d n_reads got=%0d exp=0", l, s_nrd); end
            checks++; if (s_done_cyc !== 2 || s_ndone !== 1) begin failures++;
                $display("FAIL food_only len=%0d done_cycle got=%0d/%0d exp=2/1", l, s_done_cyc, s_ndone); end
            checks++; if (hf_tr[2] !== 1'b1 || hb_tr[2] !== 1'b0 || hi_tr[2] !== 5'd0) begin failures++;
                $display("FAIL food_only len=%0d result got=%b/%b/%0d exp=1/0/0", l, hf_tr[2], hb_tr[2], hi_tr[2]); end
            $display("food_only len=%0d: reads=%0d done@%0d food=%b", l, s_nrd, s_done_cyc, hf_tr[2]);
        end
    endtask

    task test_full_scan();
        fill_ram();
        pulse_start(20'h0ABCD, 20'h00002, 6'd32);
        capture(37); summarize(37);
        checks++; if (s_nrd !== 31 || s_contig !== 1) begin failures++;
            $display("FAIL full_scan reads got=%0d/%0d exp=31/1", s_nrd, s_contig); end
        checks++; if (s_done_cyc !== 34 || s_ndone !== 1) begin failures++;
            $display("FAIL full_scan done_cycle got=%0d/%0d exp=34/1", s_done_cyc, s_ndone); end
        checks++; if (hb_tr[34] !== 1'b0 || hi_tr[34] !== 5'd0 || hf_tr[34] !== 1'b0) begin failures++;
            $display("FAIL full_scan result got=%b/%0d/%b exp=0/0/0", hb_tr[34], hi_tr[34], hf_tr[34]); end
        $display("full_scan len=32: reads=%0d done@%0d", s_nrd, s_done_cyc);
        ram[31] = 20'h0ABCD;
        pulse_start(20'h0ABCD, 20'h0ABCD, 6'd63);
        capture(37); summarize(37);
        checks++; if (s_nrd !== 31 || s_contig !== 1) begin failures++;
            $display("FAIL clamp reads got=%0d/%0d exp=31/1", s_nrd, s_contig); end
        checks++; if (s_done_cyc !== 34) begin failures++; $display("FAIL clamp done_cycle got=%0d exp=34", s_done_cyc); end
        checks++; if (hb_tr[34] !== 1'b1 || hi_tr[34] !== 5'd31 || hf_tr[34] !== 1'b1) begin failures++;
            $display("FAIL clamp result got=%b/%0d/%b exp=1/31/1", hb_tr[34], hi_tr[34], hf_tr[34]); end
        $display("clamp len=63: reads=%0d done@%0d idx=%0d", s_nrd, s_done_cyc, hi_tr[34]);
    endtask

    task test_ignored_start();
        fill_ram();
        ram[3] = 20'h31111;
        pulse_start(20'h2A0B5, 20'h2A0B5, 6'd6);
        fork
            capture(11);
            begin
                @(negedge clk); @(negedge clk);
                head = 20'h31111; food = 20'h00000; length = 6'd2; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        join
        summarize(11);
        checks++; if (s_nrd !== 5 || s_contig !== 1) begin failures++;
            $display("FAIL ignored_start reads got=%0d/%0d exp=5/1", s_nrd, s_contig); end
        checks++; if (s_done_cyc !== 8 || s_ndone !== 1) begin failures++;
            $display("FAIL ignored_start done_cycle got=%0d/%0d exp=8/1", s_done_cyc, s_ndone); end
        checks++; if (hb_tr[8] !== 1'b0 || hi_tr[8] !== 5'd0 || hf_tr[8] !== 1'b1) begin failures++;
            $display("FAIL ignored_start result got=%b/%0d/%b exp=0/0/1", hb_tr[8], hi_tr[8], hf_tr[8]); end
        $display("ignored_start: reads=%0d done@%0d food=%b", s_nrd, s_done_cyc, hf_tr[8]);
    endtask

    task test_abort();
        fill_ram();
        ram[2] = 20'h15A5A;
        pulse_start(20'h15A5A, 20'h15A5A, 6'd6);
        capture(2);
        @(negedge clk); reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++; if ({seg_rd, seg_addr, busy, done, hit_body, hit_index, hit_food} !== '0) begin failures++;
            $display("FAIL abort_outputs got=%b/%0d/%b/%b/%b/%0d/%b exp=all0",
                     seg_rd, seg_addr, busy, done, hit_body, hit_index, hit_food); end
        pulse_start(20'h15A5A, 20'h00003, 6'd3);
        capture(8); summarize(8);
        checks++; if (s_nrd !== 2 || s_contig !== 1) begin failures++;
            $display("FAIL abort_restart reads got=%0d/%0d exp=2/1", s_nrd, s_contig); end
        checks++; if (s_done_cyc !== 5 || s_ndone !== 1) begin failures++;
            $display("FAIL abort_restart done_cycle got=%0d/%0d exp=5/1", s_done_cyc, s_ndone); end
        checks++; if (hb_tr[5] !== 1'b1 || hi_tr[5] !== 5'd2 || hf_tr[5] !== 1'b0) begin failures++;
            $display("FAIL abort_restart result got=%b/%0d/%b exp=1/2/0", hb_tr[5], hi_tr[5], hf_tr[5]); end
        $display("abort: restart reads=%0d done@%0d idx=%0d", s_nrd, s_done_cyc, hi_tr[5]);
    endtask

    task test_back_to_back();
        fill_ram();
        ram[1] = 20'h0F0F0;
        pulse_start(20'h01234, 20'h00005, 6'd2);
        capture(3);
        @(negedge clk);
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%b exp=1", done); end
        head = 20'h0F0F0; length = 6'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++;
            $display("FAIL b2b_report_start busy/done got=%b/%b exp=0/0", busy, done); end
        pulse_start(20'h0F0F0, 20'h00005, 6'd2);
        capture(4); summarize(4);
        checks++; if (s_done_cyc !== 4 || hb_tr[4] !== 1'b1 || hi_tr[4] !== 5'd1) begin failures++;
            $display("FAIL b2b_first got=%0d/%b/%0d exp=4/1/1", s_done_cyc, hb_tr[4], hi_tr[4]); end
        pulse_start(20'h01234, 20'h01234, 6'd2);
        capture(5); summarize(5);
        checks++; if (s_done_cyc !== 4 || s_nrd !== 1 || hb_tr[4] !== 1'b0 || hf_tr[4] !== 1'b1) begin failures++;
            $display("FAIL b2b_second got=%0d/%0d/%b/%b exp=4/1/0/1", s_done_cyc, s_nrd, hb_tr[4], hf_tr[4]); end
        $display("back_to_back: second scan done@%0d hit=%b food=%b", s_done_cyc, hb_tr[4], hf_tr[4]);
    endtask

    initial begin
        test_reset();
        test_body_last();
        test_early_hit();
        test_food_only();
        test_full_scan();
        test_ignored_start();
        test_abort();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/snake_collision_scan.md
# snake_collision_scan

Sequencer that shares the team's 20-bit equality comparator (`twentyBitComparitor`, output F low when equal) to check the snake head against every stored body segment and the food position once per game tick. It sits between the game-tick controller, which issues `start`, and the segment RAM, which it reads one word per cycle. It reports a body hit with the matching index, and a food hit. Positions are packed as x in [19:10] and y in [9:0].

## Interface

**Parameters**

- `ADDR_W`, default 5: segment RAM address width. Maximum snake length is 2^ADDR_W.

**Ports** (one clock; reset is synchronous and active-high)

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request. Accepted only in IDLE; ignored otherwise.
- `head`  in  20  head position. Captured when `start` is accepted.
- `food`  in  20  food position. Captured when `start` is accepted.
- `length`  in  ADDR_W+1  segment count, including the head at index 0. Captured when `start` is accepted.
- `seg_rd`  out  1  segment RAM read strobe.
- `seg_addr`  out  ADDR_W  segment RAM read address.
- `seg_data`  in  20  read data. Valid the cycle after `seg_rd` (synchronous RAM).
- `busy`  out  1  scan in progress.
- `done`  out  1  one-cycle pulse; results are valid in this cycle.
- `hit_body`  out  1  head equals some segment 1..length-1.
- `hit_index`  out  ADDR_W  lowest matching segment index; 0 if there is no hit.
- `hit_food`  out  1  head equals food.

## Operation

**States:** IDLE, SCAN, FOOD, REPORT.

- **Reset.** Go to IDLE. All outputs are 0: `seg_rd`, `seg_addr`, `busy`, `done`, `hit_body`, `hit_index`, `hit_food`.
- **IDLE + start.**
  - Latch `head`, `food` and `length`. A `length` of 0 is treated as 1; a `length` above 2^ADDR_W is clamped to 2^ADDR_W.
  - Clear `hit_body`, `hit_index` and `hit_food`.
  - If the effective length is 1 or less, go to FOOD; otherwise go to SCAN with the read pointer at 1.
- **SCAN.**
  - Issue reads at addresses 1..len-1, one per cycle. Hold `seg_rd` high for exactly len-1 consecutive cycles.
  - Each returned word goes through comparator instance 0 against the latched head in the cycle it arrives.
  - **First match at index k:** set `hit_body`, set `hit_index=k`, drop `seg_rd` immediately, discard the in-flight read of k+1, and go to FOOD.
  - **No match:** after the compare of index len-1, go to FOOD.
  - Index 0 (the head itself) is never read.
- **FOOD.** Comparator instance 1 compares the latched head with the latched food. Register `hit_food`, then go to REPORT.
- **REPORT.** Assert `done` for one cycle and return to IDLE.
  - Results hold until the next accepted `start`.
  - A `start` arriving in the REPORT cycle is ignored.
- **Equality rule.** Equality is taken only from the inverted comparator F. There is no separate `==` in the datapath.
- **Busy.** `busy` is high in SCAN, FOOD and REPORT; low in IDLE.
- **Reset mid-operation.** Return to IDLE with all outputs 0. No `done` is produced for the aborted scan.

## Timing

Cycle 0 is the edge on which `start` is sampled in IDLE.

- **len ≥ 2, no body hit:**
  - `seg_addr`=k with `seg_rd`=1 in cycle k, for k=1..len-1.
  - The compare of index k happens in cycle k+1.
  - FOOD in cycle len+1; `done` in cycle len+2.
- **Body hit at index k:** the compare is in cycle k+1, FOOD in cycle k+2, `done` in cycle k+3. `seg_rd` is 0 from cycle k+2 onward.
- **len ≤ 1:** FOOD in cycle 1, `done` in cycle 2, and `seg_rd` is never asserted.
- **Next start:** the earliest next `start` that is accepted is in the cycle after `done`.
- **Output timing:** all outputs are registered, with no combinational path from input to output.

## Test plan

- **Reset values:** hold `reset` for 2 cycles → every output reads 0. Toggling `start` while `reset` is high → nothing happens.
- **Body hit at last segment:** `length`=5, `head`=0x0A00B, RAM[1..4]=0x0300C, 0x0500C, 0x0700C, 0x0A00B, `food`=0x01001.
  - `seg_addr` steps 1,2,3,4 in cycles 1–4.
  - `done` in cycle 7 with `hit_body`=1, `hit_index`=4, `hit_food`=0.
- **Early hit:** `length`=8 and RAM[2]=`head`.
  - Only addresses 1..3 are issued; `seg_rd`=0 from cycle 4.
  - `done` in cycle 5 with `hit_index`=2. RAM[5]=`head` too → still reports index 2.
- **No body, food hit:** `length`=1 and `food`=`head`=0x12345.
  - `seg_rd` is never high.
  - `done` in cycle 2 with `hit_food`=1, `hit_body`=0.
  - Repeat with `length`=0 → identical result.
- **Full-length scan:** ADDR_W=5, `length`=32, no match anywhere.
  - Addresses 1..31 are issued.
  - `done` in cycle 34 with all hit flags 0 and `hit_index`=0.
- **Ignored start and abort:**
  - Pulse `start` in cycle 2 of a `length`=6 scan → latched values are unchanged and `done` timing is unaffected.
  - Separately, assert `reset` in cycle 3 → all outputs are 0 in cycle 4, and no `done` follows.
  - A new `start` in cycle 5 is accepted and runs normally.
